// File: rtl/parallel_gate_arb_pkg.sv
// parallel_gate_arb_pkg: opcode and FSM state types shared by the gate arbiter
// and its ALU.
package parallel_gate_arb_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/parallel_gate_alu.sv
// parallel_gate_alu: one shared copy of the bitwise gate array plus an opcode
// result mux. Also holds the parallel_gate_* primitives it is built from.

module parallel_gate_and #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a & b;
endmodule

module parallel_gate_nand #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a & b);
endmodule

module parallel_gate_or #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a | b;
endmodule

module parallel_gate_nor #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a | b);
endmodule

module parallel_gate_xor #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a ^ b;
endmodule

module parallel_gate_xnor #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a ^ b);
endmodule

module parallel_gate_alu
  import parallel_gate_arb_pkg::*;
#(
  parameter  int S = 3,
  localparam int W = 2**S
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W-1:0] y_and, y_nand, y_or, y_nor, y_xor, y_xnor;

  parallel_gate_and  #(.W(W)) u_and  (.a(a), .b(b), .y(y_and));
  parallel_gate_nand #(.W(W)) u_nand (.a(a), .b(b), .y(y_nand));
  parallel_gate_or   #(.W(W)) u_or   (.a(a), .b(b), .y(y_or));
  parallel_gate_nor  #(.W(W)) u_nor  (.a(a), .b(b), .y(y_nor));
  parallel_gate_xor  #(.W(W)) u_xor  (.a(a), .b(b), .y(y_xor));
  parallel_gate_xnor #(.W(W)) u_xnor (.a(a), .b(b), .y(y_xnor));

  // Select the gate output for the requested opcode.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = y_and;
      OP_OR:   y = y_or;
      OP_NAND: y = y_nand;
      OP_NOR:  y = y_nor;
      OP_XOR:  y = y_xor;
      OP_XNOR: y = y_xnor;
      OP_NOTA: y = ~a;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/parallel_gate_arbiter.sv
// parallel_gate_arbiter: shares one parallel_gate_alu between N requesters.
// IDLE grants and latches, EXEC registers the result, RESP holds it until
// taken. Define PARALLEL_GATE_ARB_RR_EN for round-robin; otherwise the lowest
// valid index always wins.
module parallel_gate_arbiter
  import parallel_gate_arb_pkg::*;
#(
  parameter  int S  = 3,
  parameter  int N  = 4,
  localparam int W  = 2**S,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [OPW*N-1:0]  req_op,
  input  logic [N*W-1:0]    req_a,
  input  logic [N*W-1:0]    req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_data
);

  state_t          state;
  op_t             op_q;
  logic [W-1:0]    a_q, b_q, alu_y;
  logic [IW-1:0]   id_q, gidx, p;
  logic [N-1:0]    grant;
  logic            found;
  int unsigned     idx;

`ifdef PARALLEL_GATE_ARB_RR_EN
  // Rotate the search start to just past the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else if (state == IDLE && found)
      p <= (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;
  end
`else
  assign p = '0;
`endif

  // Scan p, p+1, ... mod N; first valid requester wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = k + int'(p);
      if (idx >= N) idx = idx - N;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx[IW-1:0];
      end
    end
  end

  // Reset masks the accept so all outputs read zero while rst_n is low.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;

  parallel_gate_alu #(.S(S)) u_alu (.op(op_q), .a(a_q), .b(b_q), .y(alu_y));

  // Sequencer: latch the winner, register the result, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_AND;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_q  <= op_t'(req_op[OPW*int'(gidx) +: OPW]);
          a_q   <= req_a[W*int'(gidx) +: W];
          b_q   <= req_b[W*int'(gidx) +: W];
          id_q  <= gidx;
          state <= EXEC;
        end
        EXEC: begin
          rsp_data  <= alu_y;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_gate_arbiter.sv
// tb_parallel_gate_arbiter: directed vectors and corner sequences for the
// shared gate arbiter at S=3, N=4.
module tb_parallel_gate_arbiter;
  import parallel_gate_arb_pkg::*;

  localparam int S  = 3;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [3*N-1:0]    req_op;
  logic [N*W-1:0]    req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   ord[5];

  always #5 clk = ~clk;

  parallel_gate_arbiter #(.S(S), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[3*i +: 3] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
    req_valid[i]     = 1'b1;
  endtask

  // Full transaction with rsp_ready high; starts and ends 1 time unit into an IDLE cycle.
  task automatic issue(input string nm, input int i, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    set_req(i, op, a, b);
    #1;
    chk({nm, " ready"}, 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk({nm, " exec_valid"}, 32'(rsp_valid), 32'(0));
    chk({nm, " exec_ready"}, 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(1));
    chk({nm, " rsp_data"}, 32'(rsp_data), 32'(exp));
    chk({nm, " rsp_id"}, 32'(rsp_id), 32'(i));
    @(posedge clk); #1;
    chk({nm, " idle_valid"}, 32'(rsp_valid), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{3'd0, 8'hCC, 8'hAA, 8'h88};
    tbl[1] = '{3'd1, 8'hCC, 8'hAA, 8'hEE};
    tbl[2] = '{3'd2, 8'hCC, 8'hAA, 8'h77};
    tbl[3] = '{3'd3, 8'hCC, 8'hAA, 8'h11};
    tbl[4] = '{3'd4, 8'hCC, 8'hAA, 8'h66};
    tbl[5] = '{3'd5, 8'hCC, 8'hAA, 8'h99};
    tbl[6] = '{3'd6, 8'hCC, 8'hAA, 8'h33};
    tbl[7] = '{3'd7, 8'hCC, 8'hAA, 8'hCC};
`ifdef PARALLEL_GATE_ARB_RR_EN
    ord = '{0, 1, 2, 3, 0};
`else
    ord = '{0, 0, 0, 0, 0};
`endif

    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset rsp_data", 32'(rsp_data), 32'(0));
    chk("reset rsp_id", 32'(rsp_id), 32'(0));
    chk("reset req_ready", 32'(req_ready), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, NOR.
    issue("single", 2, 3'd3, 8'hF0, 8'h0F, 8'h00);

    // All opcodes from requester 0.
    foreach (tbl[v]) issue($sformatf("op%0d", v), 0, tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].exp);

    // Contention: all requesters held valid from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'd7, 8'h10 + 8'(i), 8'h00);
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[ord[g]] = 1'b1;
      #1;
      chk($sformatf("cont%0d ready", g), 32'(req_ready), 32'(oh));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("cont%0d id", g), 32'(rsp_id), 32'(ord[g]));
      chk($sformatf("cont%0d data", g), 32'(rsp_data), 32'(8'h10 + 8'(ord[g])));
      if (g == 4) req_valid = '0;
      @(posedge clk); #1;
    end

    // Backpressure: hold RESP for five cycles with another requester waiting.
    rsp_ready = 1'b0;
    set_req(3, 3'd4, 8'h5A, 8'hFF);
    #1;
    chk("bp ready", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    set_req(0, 3'd0, 8'h0F, 8'h3C);
    chk("bp exec_ready", 32'(req_ready), 32'(0));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d valid", c), 32'(rsp_valid), 32'(1));
      chk($sformatf("bp%0d data", c), 32'(rsp_data), 32'(8'hA5));
      chk($sformatf("bp%0d id", c), 32'(rsp_id), 32'(3));
      chk($sformatf("bp%0d ready", c), 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp handshake ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    chk("bp idle valid", 32'(rsp_valid), 32'(0));
    issue("bp next", 0, 3'd0, 8'h0F, 8'h3C, 8'h0C);

    // Reset asserted in EXEC abandons the transaction.
    set_req(2, 3'd7, 8'h77, 8'h00);
    #1;
    chk("mid ready", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 32'(rsp_valid), 32'(0));
    chk("mid rst data", 32'(rsp_data), 32'(0));
    chk("mid rst id", 32'(rsp_id), 32'(0));
    set_req(0, 3'd7, 8'h3C, 8'h00);
    set_req(3, 3'd7, 8'h4D, 8'h00);
    #1;
    chk("mid rst ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid rst no rsp", 32'(rsp_valid), 32'(0));
    rst_n = 1'b1;
    issue("post rst", 0, 3'd7, 8'h3C, 8'h00, 8'h3C);
    issue("post rst 3", 3, 3'd7, 8'h4D, 8'h00, 8'h4D);

    // Requester 1 pulses valid only while the FSM is in RESP.
    set_req(0, 3'd4, 8'hFF, 8'h0F);
    #1;
    chk("wd ready", 32'(req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1, 3'd7, 8'hEE, 8'h00);
    #1;
    chk("wd resp ready", 32'(req_ready), 32'(0));
    chk("wd rsp_data", 32'(rsp_data), 32'(8'hF0));
    chk("wd rsp_id", 32'(rsp_id), 32'(0));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    chk("wd hold valid", 32'(rsp_valid), 32'(1));
    @(posedge clk); #1;
    chk("wd idle ready", 32'(req_ready), 32'(0));
    chk("wd idle valid", 32'(rsp_valid), 32'(0));
    issue("wd next", 3, 3'd1, 8'h81, 8'h18, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
